// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to a
// variable-latency instruction memory, tags each request with {pc, epoch,
// stale}, buffers good responses in a small FIFO and feeds the IF/ID register.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_stage #(
    parameter int PC_W       = 9,
    parameter int INSTR_W    = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    input  logic               halt_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               ifid_valid_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_discard_cnt_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    pc;
    logic               epoch;

    // In-flight tag queue; one entry per outstanding memory request.
    logic [PC_W-1:0]    tq_pc    [FIFO_DEPTH];
    logic               tq_epoch [FIFO_DEPTH];
    logic               tq_stale [FIFO_DEPTH];
    logic [PTR_W-1:0]   tq_wr;
    logic [PTR_W-1:0]   tq_rd;
    logic [CNT_W-1:0]   tq_count;

    // Instruction FIFO between memory responses and IF/ID.
    logic [PC_W-1:0]    fq_pc    [FIFO_DEPTH];
    logic [INSTR_W-1:0] fq_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]   fq_wr;
    logic [PTR_W-1:0]   fq_rd;
    logic [CNT_W-1:0]   fq_count;

    logic               pop;
    logic               issue;
    logic               tq_pop;
    logic               resp_keep;
    logic               resp_drop;
    logic [CNT_W:0]     credit_used;
    logic               unused_ok;

    // Credit, issue and response classification; the credit counts a same-cycle pop
    // so a latency-1 memory sustains one instruction per cycle.
    always_comb begin
        pop         = !redirect_i && !stall_i && (fq_count != '0);
        credit_used = {1'b0, tq_count} + {1'b0, fq_count} - {{CNT_W{1'b0}}, pop};
        issue       = !reset && !halt_i && !redirect_i
                      && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        tq_pop      = imem_rvalid_i && (tq_count != '0);
        resp_keep   = tq_pop && !redirect_i && (tq_epoch[tq_rd] == epoch) && !tq_stale[tq_rd];
        resp_drop   = tq_pop && !resp_keep;
    end

    assign imem_req_o  = issue;
    assign imem_addr_o = pc;
    assign unused_ok   = ^{redirect_pc_i[1:0], resp_drop};

    // PC and epoch: redirect restarts on a word-aligned target, issue advances by 4 with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= PC_W'(RESET_PC);
            epoch <= 1'b0;
        end else if (redirect_i) begin
            pc    <= {redirect_pc_i[PC_W-1:2], 2'b00};
            epoch <= ~epoch;
        end else if (issue) begin
            pc    <= pc + PC_W'(4);
        end
    end

    // Tag queue: a redirect marks every outstanding entry stale so back-to-back
    // redirects cannot alias through the single-bit epoch.
    always_ff @(posedge clk) begin
        if (reset) begin
            tq_wr    <= '0;
            tq_rd    <= '0;
            tq_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tq_stale[i] <= 1'b0;
        end else begin
            if (redirect_i) begin
                for (int i = 0; i < FIFO_DEPTH; i++) tq_stale[i] <= 1'b1;
            end
            if (issue) begin
                tq_pc[tq_wr]    <= pc;
                tq_epoch[tq_wr] <= epoch;
                tq_stale[tq_wr] <= 1'b0;
                tq_wr           <= tq_wr + PTR_W'(1);
            end
            if (tq_pop) tq_rd <= tq_rd + PTR_W'(1);
            tq_count <= tq_count + CNT_W'(issue) - CNT_W'(tq_pop);
        end
    end

    // Instruction FIFO: cleared on redirect; push and pop may coincide, no bypass.
    always_ff @(posedge clk) begin
        if (reset || redirect_i) begin
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_count <= '0;
        end else begin
            if (resp_keep) begin
                fq_pc[fq_wr]    <= tq_pc[tq_rd];
                fq_instr[fq_wr] <= imem_rdata_i;
                fq_wr           <= fq_wr + PTR_W'(1);
            end
            if (pop) fq_rd <= fq_rd + PTR_W'(1);
            fq_count <= fq_count + CNT_W'(resp_keep) - CNT_W'(pop);
        end
    end

    // IF/ID register: redirect bubbles, stall holds, otherwise load head or a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= '0;
        end else if (redirect_i) begin
            ifid_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (fq_count != '0) begin
                ifid_valid_o <= 1'b1;
                ifid_pc_o    <= fq_pc[fq_rd];
                ifid_instr_o <= fq_instr[fq_rd];
            end else begin
                ifid_valid_o <= 1'b0;
            end
        end
    end

`ifdef IF_FETCH_PERF_EN
    // Issued-request and stale-discard counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt_o   <= '0;
            perf_discard_cnt_o <= '0;
        end else begin
            if (issue)     perf_fetch_cnt_o   <= perf_fetch_cnt_o + 32'd1;
            if (resp_drop) perf_discard_cnt_o <= perf_discard_cnt_o + 32'd1;
        end
    end
`else
    // Counters absent; fetch behaviour is unchanged.
`endif

    // Memory never answers without an outstanding request.
    a_resp_has_tag: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid_i |-> (tq_count != '0));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order fixed-latency memory model.
// Every cycle line gives inputs and the hand-derived request / IF/ID outputs.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [8:0]  redirect_pc_i;
    logic        halt_i;
    logic        imem_req_o;
    logic [8:0]  imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [8:0]  ifid_pc_o;
    logic [31:0] ifid_instr_o;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_discard_cnt_o;
`endif

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o   (perf_fetch_cnt_o),
        .perf_discard_cnt_o (perf_discard_cnt_o)
`endif
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         lat      = 1;
    logic       s_req;
    logic [8:0] s_addr;
    logic [8:0] mq_addr [$];
    int         mq_due  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, answer from the memory model, capture the request
    // seen before the edge, then return at the following falling edge.
    task automatic step(input logic st, input logic rd, input logic [8:0] rpc, input logic hl);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        halt_i        = hl;
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hA500_0000 | {23'b0, mq_addr[0]};
            mq_due.delete(0);
            mq_addr.delete(0);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        #1;
        s_req  = imem_req_o;
        s_addr = imem_addr_o;
        if (imem_req_o) begin
            mq_addr.push_back(imem_addr_o);
            mq_due.push_back(cyc + lat);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic st, input logic rd, input logic [8:0] rpc,
                       input logic hl, input logic e_req, input logic [8:0] e_addr,
                       input logic e_v, input logic [8:0] e_pc);
        string t;
        t = $sformatf("%s_c%0d", tag, cyc);
        step(st, rd, rpc, hl);
        chk_eq({t, "_req"}, {31'b0, s_req}, {31'b0, e_req});
        if (e_req) chk_eq({t, "_addr"}, {23'b0, s_addr}, {23'b0, e_addr});
        chk_eq({t, "_valid"}, {31'b0, ifid_valid_o}, {31'b0, e_v});
        chk_eq({t, "_pc"}, {23'b0, ifid_pc_o}, {23'b0, e_pc});
        if (e_v) chk_eq({t, "_instr"}, ifid_instr_o, 32'hA500_0000 | {23'b0, e_pc});
    endtask

    task automatic do_reset(input int l);
        lat    = l;
        reset  = 1'b1;
        mq_addr.delete();
        mq_due.delete();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_eq("rst_req", {31'b0, s_req}, 32'h0);
        reset = 1'b0;
        cyc   = 0;
        chk_eq("rst_valid", {31'b0, ifid_valid_o}, 32'h0);
        chk_eq("rst_pc", {23'b0, ifid_pc_o}, 32'h0);
        chk_eq("rst_instr", ifid_instr_o, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        @(negedge clk);

        // Latency 1: back-to-back delivery from cycle 3 (end of cycle 2).
        do_reset(1);
        for (int i = 0; i < 6; i++)
            run("t1", 0, 0, 0, 0, 1, 9'(4 * i), i >= 2, (i >= 2) ? 9'(4 * (i - 2)) : 9'd0);
`ifdef IF_FETCH_PERF_EN
        chk_eq("perf_fetch", perf_fetch_cnt_o, 32'd6);
        chk_eq("perf_discard0", perf_discard_cnt_o, 32'd0);
`endif

        // Latency 3: credit limits to two outstanding, bubbles between pairs.
        do_reset(3);
        run("t2", 0, 0, 0, 0, 1, 'h000, 0, 'h000);
        run("t2", 0, 0, 0, 0, 1, 'h004, 0, 'h000);
        run("t2", 0, 0, 0, 0, 0, 'h000, 0, 'h000);
        run("t2", 0, 0, 0, 0, 0, 'h000, 0, 'h000);
        run("t2", 0, 0, 0, 0, 1, 'h008, 1, 'h000);
        run("t2", 0, 0, 0, 0, 1, 'h00C, 1, 'h004);
        run("t2", 0, 0, 0, 0, 0, 'h000, 0, 'h004);
        run("t2", 0, 0, 0, 0, 0, 'h000, 0, 'h004);
        run("t2", 0, 0, 0, 0, 1, 'h010, 1, 'h008);
        run("t2", 0, 0, 0, 0, 1, 'h014, 1, 'h00C);
        // Redirect to 0x40 with 0x10/0x14 in flight: both dropped.
        run("t4", 0, 1, 'h040, 0, 0, 'h000, 0, 'h00C);
        run("t4", 0, 0, 0, 0, 0, 'h000, 0, 'h00C);
        run("t4", 0, 0, 0, 0, 1, 'h040, 0, 'h00C);
        run("t4", 0, 0, 0, 0, 1, 'h044, 0, 'h00C);
        run("t4", 0, 0, 0, 0, 0, 'h000, 0, 'h00C);
        run("t4", 0, 0, 0, 0, 0, 'h000, 0, 'h00C);
        run("t4", 0, 0, 0, 0, 1, 'h048, 1, 'h040);
        run("t4", 0, 0, 0, 0, 1, 'h04C, 1, 'h044);

        // Stall 4 cycles while IF/ID holds pc 8, then 12,16,20 without gaps.
        do_reset(1);
        for (int i = 0; i < 5; i++)
            run("t3", 0, 0, 0, 0, 1, 9'(4 * i), i >= 2, (i >= 2) ? 9'(4 * (i - 2)) : 9'd0);
        for (int i = 0; i < 4; i++)
            run("t3s", 1, 0, 0, 0, 0, 'h000, 1, 'h008);
        run("t3", 0, 0, 0, 0, 1, 'h014, 1, 'h00C);
        run("t3", 0, 0, 0, 0, 1, 'h018, 1, 'h010);
        run("t3", 0, 0, 0, 0, 1, 'h01C, 1, 'h014);

        // Redirect to 0x41 together with stall: redirect wins, target aligned,
        // same-cycle response dropped.
        do_reset(1);
        for (int i = 0; i < 4; i++)
            run("t5", 0, 0, 0, 0, 1, 9'(4 * i), i >= 2, (i >= 2) ? 9'(4 * (i - 2)) : 9'd0);
        run("t5", 1, 1, 'h041, 0, 0, 'h000, 0, 'h004);
        run("t5", 0, 0, 0, 0, 1, 'h040, 0, 'h004);
        run("t5", 0, 0, 0, 0, 1, 'h044, 0, 'h004);
        run("t5", 0, 0, 0, 0, 1, 'h048, 1, 'h040);
        run("t5", 0, 0, 0, 0, 1, 'h04C, 1, 'h044);
`ifdef IF_FETCH_PERF_EN
        chk_eq("perf_discard1", perf_discard_cnt_o, 32'd1);
`endif

        // Halt with 0x1F8/0x1FC outstanding; both drain, then resume at wrapped pc 0.
        do_reset(3);
        run("t6", 0, 1, 'h1F8, 0, 0, 'h000, 0, 'h000);
        run("t6", 0, 0, 0, 0, 1, 'h1F8, 0, 'h000);
        run("t6", 0, 0, 0, 0, 1, 'h1FC, 0, 'h000);
        run("t6", 0, 0, 0, 1, 0, 'h000, 0, 'h000);
        run("t6", 0, 0, 0, 1, 0, 'h000, 0, 'h000);
        run("t6", 0, 0, 0, 1, 0, 'h000, 1, 'h1F8);
        run("t6", 0, 0, 0, 1, 0, 'h000, 1, 'h1FC);
        run("t6", 0, 0, 0, 1, 0, 'h000, 0, 'h1FC);
        run("t6", 0, 0, 0, 0, 1, 'h000, 0, 'h1FC);
        run("t6", 0, 0, 0, 0, 1, 'h004, 0, 'h1FC);
        run("t6", 0, 0, 0, 0, 0, 'h000, 0, 'h1FC);
        run("t6", 0, 0, 0, 0, 0, 'h000, 0, 'h1FC);
        run("t6", 0, 0, 0, 0, 1, 'h008, 1, 'h000);

        // Back-to-back redirects: epoch returns to its old value, stale flag must drop pc 4.
        do_reset(3);
        run("t7", 0, 0, 0, 0, 1, 'h000, 0, 'h000);
        run("t7", 0, 0, 0, 0, 1, 'h004, 0, 'h000);
        run("t7", 0, 1, 'h080, 0, 0, 'h000, 0, 'h000);
        run("t7", 0, 1, 'h090, 0, 0, 'h000, 0, 'h000);
        run("t7", 0, 0, 0, 0, 1, 'h090, 0, 'h000);
        run("t7", 0, 0, 0, 0, 1, 'h094, 0, 'h000);
        run("t7", 0, 0, 0, 0, 0, 'h000, 0, 'h000);
        run("t7", 0, 0, 0, 0, 0, 'h000, 0, 'h000);
        run("t7", 0, 0, 0, 0, 1, 'h098, 1, 'h090);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
